// File: rtl/flit_rx_buffer_if.sv
// Single-channel req/ack/data flit link. A flit moves on a rising edge where req and ack
// are both high; the master drives req/data, the slave drives ack.
interface flit_rx_buffer_if #(
    parameter int unsigned Width = 8
) ();
    logic             req;
    logic             ack;
    logic [Width-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/flit_rx_buffer.sv
// Receive-side flit buffer: accepts flits from an upstream req/ack link into a small FIFO,
// re-presents them downstream on the same protocol and counts accepted flits.
module flit_rx_buffer #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter int unsigned Aw    = 2,
    parameter int unsigned CntW  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    flit_rx_buffer_if.slave        rx_if,
    flit_rx_buffer_if.master       out_if,
    output logic [Aw:0]            fill_o,
    output logic [CntW-1:0]        rx_count_o
);

    localparam logic [Aw:0] FullLvl = (Aw + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Aw:0]      fill_q, fill_d;
    logic [CntW-1:0]  rx_count_q, rx_count_d;
    logic             rx_ack_q, rx_ack_d;
    logic             out_req;
    logic             push, pop;

    assign out_req = (fill_q != '0);
    assign push    = rx_if.req & rx_ack_q;
    assign pop     = out_req & out_if.ack;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        rx_count_d = rx_count_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + Aw'(1);
            rx_count_d = rx_count_q + CntW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + Aw'(1);
        end
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + (Aw + 1)'(1);
            2'b01:   fill_d = fill_q - (Aw + 1)'(1);
            default: fill_d = fill_q;
        endcase
        // Registered accept: looks only at the post-edge occupancy, never at rx_if.req.
        rx_ack_d = (fill_d != FullLvl);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            rx_count_q <= '0;
            rx_ack_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rx_count_q <= rx_count_d;
            rx_ack_q   <= rx_ack_d;
        end
    end

    // Storage needs no reset: fill/pointers clearing makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_if.data;
        end
    end

    assign rx_if.ack   = rx_ack_q;
    assign out_if.req  = out_req;
    assign out_if.data = mem_q[rd_ptr_q];
    assign fill_o      = fill_q;
    assign rx_count_o  = rx_count_q;

endmodule

// File: tb/tb_flit_rx_buffer.sv
// Self-checking bench for flit_rx_buffer: directed steps then random traffic, all checked
// against a queue-based reference model of the link and FIFO.
module tb_flit_rx_buffer;
    localparam int unsigned Width = 8;
    localparam int unsigned Depth = 4;
    localparam int unsigned Aw    = 2;
    localparam int unsigned CntW  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flit_rx_buffer_if #(.Width(Width)) up_if ();
    flit_rx_buffer_if #(.Width(Width)) dn_if ();
    logic [Aw:0]     fill;
    logic [CntW-1:0] rx_count;

    flit_rx_buffer #(.Width(Width), .Depth(Depth), .Aw(Aw), .CntW(CntW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_if      (up_if),
        .out_if     (dn_if),
        .fill_o     (fill),
        .rx_count_o (rx_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue contents, expected accept flag, accepted-flit total.
    logic [Width-1:0] mq[$];
    logic             ack_m;
    int unsigned      cnt_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rx_ack", 32'(up_if.ack), 32'(ack_m));
        chk("out_req", 32'(dn_if.req), 32'(mq.size() != 0));
        chk("fill", 32'(fill), 32'(mq.size()));
        chk("rx_count", 32'(rx_count), cnt_m & 32'hFFFF);
        if (mq.size() != 0) chk("out_data", 32'(dn_if.data), 32'(mq[0]));
    endtask

    task automatic model_reset();
        mq.delete();
        ack_m = 1'b0;
        cnt_m = 0;
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge.
    task automatic cycle(input logic req, input logic [Width-1:0] d, input logic oack,
                         output bit acc, output bit popped, output logic [Width-1:0] head);
        up_if.req  = req;
        up_if.data = d;
        dn_if.ack  = oack;
        acc    = rst_n && req && ack_m;
        popped = rst_n && (mq.size() != 0) && oack;
        head   = dn_if.data;
        @(posedge clk);
        if (rst_n) begin
            if (popped) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(d);
                cnt_m++;
            end
            ack_m = (mq.size() != Depth);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic step(input logic req, input logic [Width-1:0] d, input logic oack);
        bit a, p;
        logic [Width-1:0] h;
        cycle(req, d, oack, a, p, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit a, p;
        logic [Width-1:0] h;
        int k, idx, popped_n, max_fill;

        up_if.req = 1'b0; up_if.data = '0; dn_if.ack = 1'b0;
        model_reset();

        // Reset then idle.
        do_reset();
        step(1'b0, '0, 1'b0);
        chk("ack_after_reset", 32'(up_if.ack), 32'd1);
        step(1'b0, '0, 1'b0);

        // Single flit.
        cycle(1'b1, 8'hA5, 1'b0, a, p, h);
        chk("single_acc", 32'(a), 32'd1);
        chk("single_data", 32'(dn_if.data), 32'hA5);
        chk("single_cnt", 32'(rx_count), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("single_empty", 32'(fill), 32'd0);

        // Fill to full, 5th held, pop one, 5th accepted.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        chk("full_fill", 32'(fill), 32'd4);
        chk("full_ack", 32'(up_if.ack), 32'd0);
        cycle(1'b1, 8'd5, 1'b0, a, p, h);
        chk("full_hold", 32'(a), 32'd0);
        cycle(1'b1, 8'd5, 1'b1, a, p, h);
        chk("full_pop_head", 32'(h), 32'd1);
        chk("full_pop_noacc", 32'(a), 32'd0);
        chk("full_ack_back", 32'(up_if.ack), 32'd1);
        cycle(1'b1, 8'd5, 1'b0, a, p, h);
        chk("fifth_acc", 32'(a), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        chk("drained", 32'(fill), 32'd0);

        // Streaming with wrap.
        do_reset();
        idx = 0; k = 0; popped_n = 0; max_fill = 0;
        for (int c = 0; c < 60 && popped_n < 20; c++) begin
            cycle(idx < 20, 8'(idx), 1'b1, a, p, h);
            if (a) idx++;
            if (p) begin
                chk("stream_order", 32'(h), 32'(k));
                k++;
                popped_n++;
            end
            if (int'(fill) > max_fill) max_fill = int'(fill);
        end
        chk("stream_popped", 32'(popped_n), 32'd20);
        chk("stream_count", 32'(rx_count), 32'd20);
        chk("stream_maxfill", 32'(max_fill <= 2), 32'd1);

        // Simultaneous push/pop at fill=2.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        chk("pp_fill_pre", 32'(fill), 32'd2);
        step(1'b1, 8'h33, 1'b1);
        chk("pp_fill", 32'(fill), 32'd2);
        chk("pp_head", 32'(dn_if.data), 32'h32);

        // Reset mid-stream at fill=3.
        step(1'b1, 8'h34, 1'b0);
        chk("mid_fill3", 32'(fill), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_req", 32'(dn_if.req), 32'd0);
        chk("mid_rx_ack", 32'(up_if.ack), 32'd0);
        chk("mid_fill", 32'(fill), 32'd0);
        chk("mid_count", 32'(rx_count), 32'd0);
        model_reset();
        @(negedge clk);
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'hC1, 1'b0);
        chk("post_head", 32'(dn_if.data), 32'hC1);
        step(1'b1, 8'hC2, 1'b1);
        chk("post_head2", 32'(dn_if.data), 32'hC2);
        chk("post_fill", 32'(fill), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
